// File: rtl/sdram_burst_client.sv
// Host-side burst front end for the SDRAM controller: splits a block request into
// BURST_LEN-word commands and streams write data in / read data out, one command at a time.
package sdram_pkg;
    typedef enum logic {READ_CMD = 1'b0, WRITE_CMD = 1'b1} sdram_rw_t;

    typedef struct packed {
        logic [23:0] addr;
        sdram_rw_t   rw;
        logic        auto_precharge_en;
    } sdram_cmd_t;
endpackage

module sdram_burst_client #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  wr_in_valid,
    output logic                  wr_in_ready,
    input  logic [DATA_WIDTH-1:0] wr_in_data,
    output logic                  rd_out_valid,
    input  logic                  rd_out_ready,
    output logic [DATA_WIDTH-1:0] rd_out_data,
    output logic                  rd_out_last,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output sdram_pkg::sdram_cmd_t cmd_data,
    output logic                  wdata_valid,
    input  logic                  wdata_ready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [1:0]            wdata_dqm,
    input  logic                  resp_valid,
    output logic                  resp_ready,
    input  logic [DATA_WIDTH-1:0] resp_data,
    input  logic                  resp_last,
    output logic [2:0]            state_dbg
);
    import sdram_pkg::*;

    typedef enum logic [2:0] {IDLE, ISSUE, WDATA, RDATA, FINISH} state_t;

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BURST_LEN - 1);

    state_t                  state;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    bursts_left;
    logic [BEAT_W-1:0]       beat_cnt;

    logic                    in_wdata;
    logic                    in_rdata;
    logic                    wd_fire;
    logic                    rd_fire;
    logic                    last_beat;
    logic                    final_burst;
    logic [ADDR_WIDTH-1:0]   req_addr_aligned;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [LEN_WIDTH-1:0]    left_m1;

    // Auto-precharge closes the row when the block ends here or the next burst starts a new row.
    function automatic sdram_cmd_t make_cmd(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [LEN_WIDTH-1:0]  left,
                                            input logic                  wr);
        logic [ADDR_WIDTH-1:0] nxt;
        sdram_cmd_t            c;
        nxt = a + BURST_STEP;
        c = '0;
        c.addr = 24'(a);
        c.rw = wr ? WRITE_CMD : READ_CMD;
        c.auto_precharge_en = (left == LEN_WIDTH'(1)) || (nxt[8:0] == 9'd0);
        return c;
    endfunction

    assign state_dbg        = state;
    assign in_wdata         = (state == WDATA);
    assign in_rdata         = (state == RDATA);
    assign last_beat        = (beat_cnt == LAST_BEAT);
    assign final_burst      = (bursts_left == LEN_WIDTH'(1));
    assign req_addr_aligned = req_addr & ALIGN_MASK;
    assign next_addr        = addr_q + BURST_STEP;
    assign left_m1          = bursts_left - LEN_WIDTH'(1);

    // Every stream moves a word on a cycle where valid && ready at the rising edge;
    // in the data states both sides are wired straight through and gated by state.
    assign wdata_valid  = in_wdata & wr_in_valid;
    assign wr_in_ready  = in_wdata & wdata_ready;
    assign wdata        = in_wdata ? wr_in_data : '0;
    assign wdata_dqm    = 2'b00;
    assign rd_out_valid = in_rdata & resp_valid;
    assign resp_ready   = in_rdata & rd_out_ready;
    assign rd_out_data  = in_rdata ? resp_data : '0;
    assign rd_out_last  = in_rdata & last_beat & final_burst;
    assign wd_fire      = wdata_valid & wdata_ready;
    assign rd_fire      = rd_out_valid & rd_out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_data    <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            bursts_left <= '0;
            beat_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr_aligned;
                        bursts_left <= req_len;
                        err         <= 1'b0;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (req_len == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            cmd_valid <= 1'b1;
                            cmd_data  <= make_cmd(req_addr_aligned, req_len, req_write);
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= write_q ? WDATA : RDATA;
                    end
                end
                WDATA, RDATA: begin
                    // The local beat count decides burst boundaries; resp_last only flags disagreement.
                    if (rd_fire && (resp_last != last_beat))
                        err <= 1'b1;
                    if (wd_fire || rd_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            addr_q      <= next_addr;
                            bursts_left <= left_m1;
                            if (left_m1 == '0) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                state     <= ISSUE;
                                cmd_valid <= 1'b1;
                                cmd_data  <= make_cmd(next_addr, left_m1, write_q);
                            end
                        end
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_client.sv
// Directed bench for sdram_burst_client with a controller/host model and expected-value queues.
`timescale 1ns/1ps
module tb_sdram_burst_client;
    import sdram_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BL = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          busy, done, err;
    logic          wr_in_valid, wr_in_ready;
    logic [DW-1:0] wr_in_data;
    logic          rd_out_valid, rd_out_ready, rd_out_last;
    logic [DW-1:0] rd_out_data;
    logic          cmd_valid, cmd_ready;
    sdram_cmd_t    cmd_data;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic [1:0]    wdata_dqm;
    logic          resp_valid, resp_ready, resp_last;
    logic [DW-1:0] resp_data;
    logic [2:0]    state_dbg;
    logic [25:0]   cmd_bits;

    always #5 clk = ~clk;

    sdram_burst_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .busy(busy), .done(done), .err(err),
        .wr_in_valid(wr_in_valid), .wr_in_ready(wr_in_ready), .wr_in_data(wr_in_data),
        .rd_out_valid(rd_out_valid), .rd_out_ready(rd_out_ready),
        .rd_out_data(rd_out_data), .rd_out_last(rd_out_last),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wdata_dqm(wdata_dqm),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_last(resp_last),
        .state_dbg(state_dbg)
    );

    assign cmd_bits = {cmd_data.addr, cmd_data.rw, cmd_data.auto_precharge_en};

    int n_checks = 0;
    int n_fail   = 0;

    logic [25:0]   exp_cmd_q[$];
    logic [DW-1:0] exp_wd_q[$];
    logic [DW:0]   exp_rd_q[$];
    logic [DW-1:0] wr_src_q[$];

    bit          req_fire_s, cmd_fire_s, wd_fire_s, host_fire_s, rsp_fire_s, cmd_is_read_s;
    bit          prev_cmd_pending;
    logic [25:0] prev_cmd;
    int          rsp_pending, rsp_idx, rsp_word, wr_outstanding;
    int          bad_last_idx;
    bit          rsp_gaps, rd_toggle, cmd_rand, wd_rand;
    int          done_cnt, wd_beats, rd_beats;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_pattern(input int k);
        return DW'(32'h5A00 + k * 273);
    endfunction

    task automatic monitor();
        req_fire_s  = req_valid && req_ready;
        cmd_fire_s  = cmd_valid && cmd_ready;
        wd_fire_s   = wdata_valid && wdata_ready;
        host_fire_s = wr_in_valid && wr_in_ready;
        rsp_fire_s  = resp_valid && resp_ready;
        cmd_is_read_s = (cmd_data.rw == READ_CMD);
        if (cmd_valid && prev_cmd_pending)
            chk("cmd_stable", cmd_bits, prev_cmd);
        prev_cmd_pending = cmd_valid && !cmd_ready;
        prev_cmd = cmd_bits;
        if (cmd_fire_s) begin
            chk("cmd_overlap", rsp_pending + wr_outstanding, 0);
            chk("cmd_expected_present", exp_cmd_q.size() > 0, 1);
            if (exp_cmd_q.size() > 0)
                chk("cmd_data", cmd_bits, exp_cmd_q.pop_front());
        end
        if (wd_fire_s) begin
            wd_beats++;
            chk("wdata_dqm", wdata_dqm, 0);
            chk("wd_expected_present", exp_wd_q.size() > 0, 1);
            if (exp_wd_q.size() > 0)
                chk("wdata", wdata, exp_wd_q.pop_front());
        end
        if (rd_out_valid)
            chk("resp_ready_mirror", resp_ready, rd_out_ready);
        if (rd_out_valid && rd_out_ready) begin
            rd_beats++;
            chk("rd_expected_present", exp_rd_q.size() > 0, 1);
            if (exp_rd_q.size() > 0)
                chk("rd_last_data", {rd_out_last, rd_out_data}, exp_rd_q.pop_front());
        end
        if (done)
            done_cnt++;
    endtask

    task automatic drive();
        if (!rstn) begin
            req_valid = 1'b0;
            cmd_ready = 1'b0;
            wdata_ready = 1'b0;
            resp_valid = 1'b0;
            resp_last = 1'b0;
            resp_data = '0;
            wr_in_valid = 1'b0;
            wr_in_data = '0;
            rsp_pending = 0;
            rsp_idx = 0;
            wr_outstanding = 0;
            prev_cmd_pending = 1'b0;
            return;
        end
        if (req_fire_s)
            req_valid = 1'b0;
        if (cmd_fire_s) begin
            if (cmd_is_read_s) rsp_pending += BL;
            else wr_outstanding += BL;
        end
        if (wd_fire_s)
            wr_outstanding--;
        if (host_fire_s && wr_src_q.size() > 0)
            void'(wr_src_q.pop_front());
        wr_in_valid = (wr_src_q.size() > 0);
        wr_in_data = (wr_src_q.size() > 0) ? wr_src_q[0] : '0;
        if (rsp_fire_s) begin
            rsp_pending--;
            rsp_idx = (rsp_idx + 1) % BL;
            rsp_word++;
            resp_valid = 1'b0;
        end
        if (!resp_valid && rsp_pending > 0 && (!rsp_gaps || $urandom_range(0, 2) != 0)) begin
            resp_valid = 1'b1;
            resp_data = rd_pattern(rsp_word);
            resp_last = (bad_last_idx >= 0) ? (rsp_idx == bad_last_idx) : (rsp_idx == BL - 1);
        end
        cmd_ready = cmd_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
        wdata_ready = wd_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        rd_out_ready = rd_toggle ? ~rd_out_ready : 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic issue_req(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] len);
        req_write = wr;
        req_addr = a;
        req_len = len;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (req_fire_s) break;
        end
        chk("req_accepted", req_fire_s, 1);
    endtask

    task automatic push_cmds(input bit wr, input logic [AW-1:0] a, input int len);
        logic [AW-1:0] ad;
        logic [AW-1:0] nx;
        bit            ap;
        ad = a & ~AW'(BL - 1);
        for (int i = 0; i < len; i++) begin
            nx = ad + AW'(BL);
            ap = (i == len - 1) || (nx[8:0] == 9'd0);
            exp_cmd_q.push_back({ad, wr, ap});
            ad = nx;
        end
    endtask

    task automatic push_reads(input int nwords);
        for (int k = 0; k < nwords; k++)
            exp_rd_q.push_back({k == nwords - 1, rd_pattern(rsp_word + k)});
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000 && done_cnt == 0; i++)
            step();
        chk({tag, "_done_seen"}, done_cnt > 0, 1);
        repeat (3) step();
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_cmdq_empty"}, exp_cmd_q.size(), 0);
        chk({tag, "_wdq_empty"}, exp_wd_q.size(), 0);
        chk({tag, "_rdq_empty"}, exp_rd_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_data"}, cmd_bits, 0);
        chk({tag, "_wr_in_ready"}, wr_in_ready, 0);
        chk({tag, "_wdata_valid"}, wdata_valid, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_dqm"}, wdata_dqm, 0);
        chk({tag, "_rd_out_valid"}, rd_out_valid, 0);
        chk({tag, "_rd_out_data"}, rd_out_data, 0);
        chk({tag, "_rd_out_last"}, rd_out_last, 0);
        chk({tag, "_resp_ready"}, resp_ready, 0);
        chk({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
        wr_in_valid = 0; wr_in_data = '0; rd_out_ready = 1;
        cmd_ready = 0; wdata_ready = 0; resp_valid = 0; resp_data = '0; resp_last = 0;
        rsp_pending = 0; rsp_idx = 0; rsp_word = 0; wr_outstanding = 0;
        bad_last_idx = -1; rsp_gaps = 0; rd_toggle = 0; cmd_rand = 0; wd_rand = 0;
        done_cnt = 0; wd_beats = 0; rd_beats = 0; prev_cmd_pending = 0; prev_cmd = '0;

        // Reset values
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) step();
        rstn = 1'b1;
        repeat (2) step();

        // Write block at 0x10, two bursts, continuous data
        for (int k = 0; k < 16; k++) begin
            wr_src_q.push_back(DW'(k));
            exp_wd_q.push_back(DW'(k));
        end
        push_cmds(1'b1, 24'h000010, 2);
        done_cnt = 0; wd_beats = 0;
        issue_req(1'b1, 24'h000010, 16'd2);
        wait_done("wr_basic");
        chk("wr_basic_beats", wd_beats, 16);
        chk("wr_basic_err", err, 0);

        // Read block crossing a row at 0x200
        push_cmds(1'b0, 24'h0001F8, 2);
        push_reads(16);
        done_cnt = 0; rd_beats = 0;
        issue_req(1'b0, 24'h0001F8, 16'd2);
        wait_done("rd_row");
        chk("rd_row_beats", rd_beats, 16);
        chk("rd_row_err", err, 0);

        // Read with host backpressure, response gaps and slow command accept
        rd_toggle = 1; rsp_gaps = 1; cmd_rand = 1;
        push_cmds(1'b0, 24'h000345, 3);
        push_reads(24);
        done_cnt = 0; rd_beats = 0;
        issue_req(1'b0, 24'h000345, 16'd3);
        wait_done("rd_bp");
        chk("rd_bp_beats", rd_beats, 24);
        chk("rd_bp_err", err, 0);
        rd_toggle = 0; rsp_gaps = 0; cmd_rand = 0; rd_out_ready = 1;

        // Controller flags resp_last early on beat 6
        bad_last_idx = 5;
        push_cmds(1'b0, 24'h000080, 1);
        push_reads(8);
        done_cnt = 0; rd_beats = 0;
        issue_req(1'b0, 24'h000080, 16'd1);
        wait_done("rd_badlast");
        chk("rd_badlast_beats", rd_beats, 8);
        chk("rd_badlast_err", err, 1);
        repeat (4) step();
        chk("rd_badlast_err_sticky", err, 1);
        bad_last_idx = -1;

        // Zero-length request: err cleared on accept, done the next cycle, no command
        done_cnt = 0;
        issue_req(1'b1, 24'h000020, 16'd0);
        chk("len0_err_cleared", err, 0);
        chk("len0_done_pulse", done, 1);
        chk("len0_busy", busy, 1);
        step();
        chk("len0_done_low", done, 0);
        chk("len0_idle_busy", busy, 0);
        chk("len0_req_ready", req_ready, 1);
        chk("len0_done_cnt", done_cnt, 1);
        chk("len0_no_cmd", exp_cmd_q.size(), 0);

        // Address wrap at top of memory, write with controller backpressure
        wd_rand = 1;
        for (int k = 0; k < 16; k++) begin
            logic [DW-1:0] w;
            w = DW'($urandom_range(0, 16'hFFFF));
            wr_src_q.push_back(w);
            exp_wd_q.push_back(w);
        end
        push_cmds(1'b1, 24'hFFFFF8, 2);
        done_cnt = 0; wd_beats = 0;
        issue_req(1'b1, 24'hFFFFF8, 16'd2);
        wait_done("wr_wrap");
        chk("wr_wrap_beats", wd_beats, 16);
        wd_rand = 0;

        // Reset during the third write beat
        for (int k = 0; k < 16; k++) begin
            wr_src_q.push_back(DW'(16'h7700 + k));
            exp_wd_q.push_back(DW'(16'h7700 + k));
        end
        push_cmds(1'b1, 24'h000040, 2);
        done_cnt = 0; wd_beats = 0;
        issue_req(1'b1, 24'h000040, 16'd2);
        for (int i = 0; i < 100 && wd_beats < 3; i++)
            step();
        chk("rst_mid_reached_beat3", wd_beats, 3);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("rst_mid");
        exp_cmd_q.delete();
        exp_wd_q.delete();
        exp_rd_q.delete();
        wr_src_q.delete();
        repeat (3) step();
        rstn = 1'b1;
        repeat (4) step();
        chk("rst_mid_no_done", done_cnt, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_busy", busy, 0);

        // Recovery write after the abandoned block
        for (int k = 0; k < 8; k++) begin
            wr_src_q.push_back(DW'(16'h3300 + k));
            exp_wd_q.push_back(DW'(16'h3300 + k));
        end
        push_cmds(1'b1, 24'h000100, 1);
        done_cnt = 0; wd_beats = 0;
        issue_req(1'b1, 24'h000100, 16'd1);
        wait_done("wr_recover");
        chk("wr_recover_beats", wd_beats, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_burst_client.md
Name: sdram_burst_client

Overview:
Initiator-side front end for the SDRAM controller. It turns one host block request (start address plus burst count) into a sequence of BURST_LEN-word controller commands. On writes it streams host data into the controller's write-data port. On reads it forwards controller response beats to a host output stream with per-burst and end-of-block marking. It sits between DMA/video engines and the controller's command/wdata/resp ports, with one command in flight at a time.

Parameters:
ADDR_WIDTH, 24, word address width; matches the sdram_pkg::sdram_cmd_t addr field.
DATA_WIDTH, 16, data word width.
BURST_LEN, 8, words per controller command; must be a power of two ≤ 512.
LEN_WIDTH, 16, width of the burst-count field of a request.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  host block request valid
req_ready  out  1  request accepted when valid&&ready
req_write  in  1  1 = write block, 0 = read block
req_addr  in  ADDR_WIDTH  start word address; low log2(BURST_LEN) bits ignored (forced 0)
req_len  in  LEN_WIDTH  number of bursts
busy  out  1  request in progress
done  out  1  one-cycle pulse when a block completes
err  out  1  sticky; set on resp_last mismatch; cleared by reset or by accepting a new request
wr_in_valid / wr_in_ready / wr_in_data  in/out/in  1/1/DATA_WIDTH  host write stream
rd_out_valid / rd_out_ready  out/in  1/1  host read stream handshake
rd_out_data  out  DATA_WIDTH  read data
rd_out_last  out  1  last beat of the whole block
cmd_valid / cmd_ready  out/in  1/1  controller command handshake
cmd_data  out  sdram_pkg::sdram_cmd_t  addr, rw (READ_CMD/WRITE_CMD), auto_precharge_en
wdata_valid / wdata_ready  out/in  1/1  controller write-data handshake
wdata  out  DATA_WIDTH  write word
wdata_dqm  out  2  byte masks; constant 2'b00
resp_valid / resp_ready  in/out  1/1  controller read response handshake
resp_data  in  DATA_WIDTH  read word
resp_last  in  1  controller end-of-burst flag

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready=1. Counters cleared, cmd_data=0. Reset mid-operation abandons the block silently with no done pulse.
- States: IDLE, ISSUE, WDATA, RDATA, FINISH.
- IDLE: req_ready=1. On accept, latch write flag, aligned address, and req_len into bursts_left; clear err.
  - req_len=0 → FINISH.
  - Otherwise → ISSUE.
- ISSUE: cmd_valid=1 with cmd_data registered and stable until cmd_ready.
  - addr = current burst address; rw from latched flag.
  - auto_precharge_en=1 if this is the last burst of the block, or if the next burst address has column bits [8:0]==0 (row crossing). Otherwise 0.
  - On handshake: beat_cnt=0; → WDATA if writing, else RDATA.
- WDATA: combinational pass-through.
  - wdata_valid=wr_in_valid, wr_in_ready=wdata_ready, wdata=wr_in_data.
  - Each wdata_valid&&wdata_ready increments beat_cnt.
  - On the BURST_LEN-th beat, end the burst.
- RDATA: combinational pass-through.
  - rd_out_valid=resp_valid, resp_ready=rd_out_ready, rd_out_data=resp_data.
  - Each handshake counts a beat. rd_out_last=1 on beat BURST_LEN-1 of the final burst only.
  - If resp_last disagrees with (beat_cnt==BURST_LEN-1) on any handshake, set err. Counting continues; beat_cnt is authoritative.
- End of burst (the cycle after the last handshake):
  - address += BURST_LEN, modulo 2^ADDR_WIDTH (wraps, no error).
  - bursts_left -= 1. If it becomes 0 → FINISH, else → ISSUE.
- FINISH: done=1 for exactly one cycle, busy=0 next cycle, → IDLE.
- busy=1 in every state except IDLE.
- Outside WDATA: wr_in_ready=0 and wdata_valid=0. Outside RDATA: resp_ready=0 and rd_out_valid=0.
- Only one command outstanding. The next cmd_valid is never asserted before all beats of the previous burst have been handshaken.
- Minimum overhead is 1 cycle in ISSUE per burst plus controller latency. There is no pipelining across bursts.

Test Plan:
- Write, req_addr=0x000010, req_len=2, continuous host data 0x0000..0x000F → two WRITE cmds at 0x10 and 0x18; ap_en=0 then 1; 16 wdata beats in order; one done pulse; err=0.
- Read, req_addr=0x0001F8, req_len=2 → cmd addrs 0x1F8 (ap_en=1, row crossing) and 0x200 (ap_en=1, last); 16 rd_out beats; rd_out_last only on beat 16.
- Read with rd_out_ready toggling 1-0-1-0 and resp_valid gaps → resp_ready mirrors rd_out_ready; no beat lost or duplicated; beat count exactly 8×req_len.
- Read where the controller asserts resp_last on beat 6 of 8 → err=1 and stays set; block still completes after 8 beats; next accepted request clears err.
- req_len=0 → no cmd_valid; done pulses one cycle after accept. Also req_addr=0xFFFFF8, req_len=2 → second cmd addr wraps to 0x000000.
- Assert rstn=0 during WDATA beat 3 → all outputs at reset values asynchronously; after release, req_ready=1 and no done pulse.
